// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and sizes for the round-robin grant arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: requester count, index width, and the arbiter FSM state encoding.
package decoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: req is level-held by a requester until it is served.
//
// Signals: req[N_REQ], done (requester side); grant[N_REQ] one-hot,
// grant_idx, grant_valid, timeout (arbiter side).
interface decoder_rr_arbiter_if;
  import decoder_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  // master: requester pool; slave: the arbiter
  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_decoder3x8.sv
// 3-to-8 one-hot decoder with enable.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x (3-bit index), en (enable), y (8-bit one-hot, zero when en=0).
module decoder3x8 (
  input  logic [2:0] x,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    if (en) y[x] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter driving a 3x8 decoder to form a one-hot grant.
// Latency: req in cycle t -> grant in cycle t+1; one zero-grant cycle between grants.
// Backpressure: grant held until done, request withdrawal, or HOLD_MAX timeout.
//
// Ports: clk, rst (sync, active-high), bus (slave modport: req, done in;
// grant, grant_idx, grant_valid, timeout out).
// Parameters: HOLD_MAX (0 = no timeout), CNT_W with 2**CNT_W > HOLD_MAX.
module decoder_rr_arbiter
  import decoder_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  decoder_rr_arbiter_if.slave bus
);

  // Terminal count for the hold counter; unused when HOLD_MAX is 0.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam bit               LIMIT_EN = (HOLD_MAX != 0);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             own_req;
  logic             limit_hit;
  logic             release_now;

  // Round-robin search starting at ptr. Scanning offsets from high to low
  // lets the smallest offset (highest priority) overwrite the result last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr_q + IDX_W'(k);
      if (bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_req     = bus.req[grant_idx_q];
  assign limit_hit   = LIMIT_EN && (hold_cnt_q == LIMIT);
  assign release_now = bus.done || !own_req || limit_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        grant_valid_d = 1'b0;
        if (pick_vld) begin
          state_d       = GRANT;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_d       = GAP;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          // Only a pure hold-limit release is flagged; done or a dropped
          // request at the same time is a normal release.
          timeout_d     = !bus.done && own_req;
        end else if (hold_cnt_q != {CNT_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  decoder3x8 u_dec (
    .x  (grant_idx_q),
    .en (grant_valid_q),
    .y  (bus.grant)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter (HOLD_MAX=4).
// Directed scenarios against hand-derived constants, then random traffic
// against a cycle model that tracks only owner, pointer and held cycles.
module tb_decoder_rr_arbiter;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner=-1 means nobody holds the resource.
  int m_owner;
  int m_last;
  int m_ptr;
  int m_held;
  bit m_to;

  function automatic void model_step(input logic [7:0] r, input logic d, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner >= 0) begin
      m_held = m_held + 1;
      if (d || !r[m_owner] || (HOLD > 0 && m_held == HOLD)) begin
        m_to    = !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 0;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
  endtask

  task automatic do_reset();
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset: grant=%h valid=%b idx=%0d to=%b, want 00/0/0/0",
               bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
    end
  endtask

  task automatic test_priority_start();
    logic [7:0] exp_g [4] = '{8'h04, 8'h04, 8'h04, 8'h00};
    logic       dn    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h04, dn[i], 1'b0);
      checks++;
      if (bus.grant !== exp_g[i] || bus.grant_idx !== 3'd2) begin
        failures++;
        $display("FAIL priority_start[%0d]: grant=%h idx=%0d, want %h idx 2",
                 i, bus.grant, bus.grant_idx, exp_g[i]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_g;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      exp_g = (i % 2 == 0) ? (8'h01 << ((i / 2) % 8)) : 8'h00;
      checks++;
      if (bus.grant !== exp_g) begin
        failures++;
        $display("FAIL rotation[%0d]: grant=%h, want %h", i, bus.grant, exp_g);
      end
    end
  endtask

  // coll=1 asserts done in the 4th grant cycle; otherwise the limit fires.
  task automatic test_timeout(input bit coll);
    logic [7:0] exp_g [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
    logic       exp_t [6];
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, !coll, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(8'h01, (coll && i == 4), 1'b0);
      checks++;
      if (bus.grant !== exp_g[i] || bus.timeout !== exp_t[i]) begin
        failures++;
        $display("FAIL timeout%s[%0d]: grant=%h to=%b, want %h to=%b",
                 coll ? "_collision" : "", i, bus.grant, bus.timeout, exp_g[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_withdrawn();
    do_reset();
    step(8'h88, 1'b0, 1'b0);
    checks++;
    if (bus.grant !== 8'h08 || bus.grant_idx !== 3'd3) begin
      failures++;
      $display("FAIL withdrawn_first: grant=%h idx=%0d, want 08 idx 3", bus.grant, bus.grant_idx);
    end
    step(8'h80, 1'b0, 1'b0);
    checks++;
    if (bus.grant !== 8'h00 || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL withdrawn_drop: grant=%h to=%b, want 00 to=0", bus.grant, bus.timeout);
    end
    step(8'h80, 1'b0, 1'b0);
    checks++;
    if (bus.grant !== 8'h80 || bus.grant_idx !== 3'd7) begin
      failures++;
      $display("FAIL withdrawn_next: grant=%h idx=%0d, want 80 idx 7", bus.grant, bus.grant_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    step(8'h20, 1'b0, 1'b0);
    checks++;
    if (bus.grant !== 8'h20) begin
      failures++;
      $display("FAIL midrst_grant: grant=%h, want 20", bus.grant);
    end
    step(8'h20, 1'b0, 1'b1);
    checks++;
    if (bus.grant !== 8'h00 || bus.timeout !== 1'b0 || bus.grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL midrst_drop: grant=%h to=%b idx=%0d, want 00 0 0", bus.grant, bus.timeout, bus.grant_idx);
    end
    step(8'h21, 1'b0, 1'b0);
    checks++;
    if (bus.grant !== 8'h01 || bus.grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL midrst_ptr: grant=%h idx=%0d, want 01 idx 0", bus.grant, bus.grant_idx);
    end
  endtask

  task automatic test_stray_done();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1, 1'b0);
      checks++;
      if (bus.grant !== 8'h00 || bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin
        failures++;
        $display("FAIL stray_done[%0d]: grant=%h valid=%b idx=%0d to=%b, want all 0",
                 i, bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r = 8'h00;
    logic       d;
    logic       rs;
    logic [7:0] exp_g;
    int         err = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      // Requests mostly persist; a few bits toggle each cycle.
      r  = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      d  = ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(r, d, rs);
      exp_g = (m_owner >= 0) ? (8'h01 << m_last) : 8'h00;
      checks++;
      if (bus.grant !== exp_g || bus.grant_idx !== 3'(m_last) ||
          bus.grant_valid !== (m_owner >= 0) || bus.timeout !== m_to) begin
        failures++;
        if (err < 10)
          $display("FAIL random[%0d]: grant=%h idx=%0d valid=%b to=%b, want %h idx=%0d valid=%b to=%b",
                   i, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout,
                   exp_g, m_last, (m_owner >= 0), m_to);
        err++;
      end
    end
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst      = 1'b1;
    m_owner  = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 0;
    test_reset();
    test_priority_start();
    test_rotation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_withdrawn();
    test_reset_mid_grant();
    test_stray_done();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
